// File: rtl/token_run_encoder.sv
// Measures runs of consecutive '1' tokens on a serial stream and queues each
// finished run length (with a saturation flag) in a small FIFO drained by valid/ready.
module token_run_encoder #(
    parameter int LEN_W = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     a,
    output logic                     run_valid,
    input  logic                     run_ready,
    output logic [LEN_W-1:0]         run_len,
    output logic                     run_sat,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [LEN_W-1:0] MAX_RUN = '1;

    typedef enum logic {
        IDLE,
        RUN
    } state_t;

    state_t             state, state_nxt;
    logic [LEN_W-1:0]   run_cnt, run_cnt_nxt;
    logic               sat_q, sat_nxt;
    logic               push;

    logic [LEN_W-1:0]   mem_len [DEPTH];
    logic               mem_sat [DEPTH];
    logic [PTR_W-1:0]   wr_ptr, rd_ptr;
    logic               full, pop, push_ok;

    // NOTE: every output of this block gets a default first so no path leaves a value held, which would infer a latch.
    always_comb begin
        state_nxt   = state;
        run_cnt_nxt = run_cnt;
        sat_nxt     = sat_q;
        push        = 1'b0;
        case (state)
            IDLE: begin
                if (a) begin
                    state_nxt   = RUN;
                    run_cnt_nxt = LEN_W'(1);
                end
            end
            RUN: begin
                if (a) begin
                    if (run_cnt == MAX_RUN) sat_nxt = 1'b1;
                    else                    run_cnt_nxt = run_cnt + 1'b1;
                end else begin
                    push        = 1'b1;
                    run_cnt_nxt = '0;
                    sat_nxt     = 1'b0;
                    state_nxt   = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            run_cnt <= '0;
            sat_q   <= 1'b0;
        end else begin
            state   <= state_nxt;
            run_cnt <= run_cnt_nxt;
            sat_q   <= sat_nxt;
        end
    end

    assign run_valid = (count != '0);
    assign full      = (count == CNT_W'(DEPTH));
    assign pop       = run_valid & run_ready;
    // A pop on the same edge frees the slot a full FIFO needs for the push.
    assign push_ok   = push & (~full | pop);

    // NOTE: record storage is not reset; count alone decides which entries are meaningful.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_len[wr_ptr] <= run_cnt;
            mem_sat[wr_ptr] <= sat_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop)     rd_ptr <= rd_ptr + 1'b1;
            case ({push_ok, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            if (push && !push_ok) overflow <= 1'b1;
        end
    end

    assign run_len = run_valid ? mem_len[rd_ptr] : '0;
    assign run_sat = run_valid ? mem_sat[rd_ptr] : 1'b0;

endmodule

// File: tb/tb_token_run_encoder.sv
// Directed and model-based checks for token_run_encoder (LEN_W=8, DEPTH=4).
module tb_token_run_encoder;

    localparam int LEN_W = 8;
    localparam int DEPTH = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic             a;
    logic             run_valid;
    logic             run_ready;
    logic [LEN_W-1:0] run_len;
    logic             run_sat;
    logic [2:0]       count;
    logic             overflow;

    int n_checks = 0;
    int n_pass   = 0;

    typedef struct {
        int unsigned len;
        bit          sat;
    } rec_t;

    token_run_encoder #(.LEN_W(LEN_W), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .a         (a),
        .run_valid (run_valid),
        .run_ready (run_ready),
        .run_len   (run_len),
        .run_sat   (run_sat),
        .count     (count),
        .overflow  (overflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int unsigned got, input int unsigned exp);
        n_checks++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    // Inputs change 1 time unit after an edge; outputs are sampled at the same point.
    task automatic tick(input logic ai, input logic ri);
        a         = ai;
        run_ready = ri;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick(1'b0, 1'b0);
        tick(1'b0, 1'b0);
        rst = 1'b0;
    endtask

    task automatic run_of(input int len, input logic ri);
        for (int i = 0; i < len; i++) tick(1'b1, ri);
        tick(1'b0, ri);
    endtask

    initial begin
        logic [9:0] seq1;
        logic [9:0] exp_v1;
        int         exp_l1 [10];
        rec_t        q[$];
        bit          m_run;
        int unsigned m_cnt;
        bit          m_sat;
        bit          m_ovf;
        logic        ra, rr;

        rst = 1'b1; a = 1'b0; run_ready = 1'b0;
        do_reset();
        check("rst_valid", run_valid, 0);
        check("rst_count", count, 0);
        check("rst_ovf", overflow, 0);
        check("rst_len", run_len, 0);
        check("rst_sat", run_sat, 0);

        // Test 1: a = 0,1,1,0,1,1,1,0,1,0 in time order with ready held high.
        seq1   = 10'b0101110110;
        exp_v1 = 10'b1010001000;
        exp_l1 = '{0, 0, 0, 2, 0, 0, 0, 3, 0, 1};
        for (int i = 0; i < 10; i++) begin
            tick(seq1[i], 1'b1);
            check($sformatf("t1_valid[%0d]", i), run_valid, exp_v1[i]);
            check($sformatf("t1_len[%0d]", i), run_len, exp_l1[i]);
        end
        tick(1'b0, 1'b1);
        check("t1_drained", run_valid, 0);

        // Test 2: saturation boundary.
        run_of(300, 1'b0);
        check("t2_len300", run_len, 255);
        check("t2_sat300", run_sat, 1);
        check("t2_count300", count, 1);
        tick(1'b0, 1'b1);
        check("t2_pop", count, 0);
        run_of(255, 1'b0);
        check("t2_len255", run_len, 255);
        check("t2_sat255", run_sat, 0);
        tick(1'b0, 1'b1);

        // Test 3: five runs with ready low overflow a depth-4 FIFO.
        do_reset();
        for (int i = 0; i < 4; i++) run_of(1, 1'b0);
        check("t3_full_count", count, 4);
        check("t3_ovf_before", overflow, 0);
        run_of(1, 1'b0);
        check("t3_count_after_drop", count, 4);
        check("t3_ovf_after", overflow, 1);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("t3_drain_valid[%0d]", i), run_valid, 1);
            check($sformatf("t3_drain_len[%0d]", i), run_len, 1);
            tick(1'b0, 1'b1);
        end
        check("t3_empty", run_valid, 0);
        check("t3_ovf_sticky", overflow, 1);

        // Test 4: push and pop on the same edge while full.
        do_reset();
        check("t4_ovf_cleared", overflow, 0);
        for (int i = 1; i <= 4; i++) run_of(i, 1'b0);
        check("t4_full", count, 4);
        for (int i = 0; i < 5; i++) tick(1'b1, 1'b0);
        tick(1'b0, 1'b1);
        check("t4_count", count, 4);
        check("t4_ovf", overflow, 0);
        for (int i = 2; i <= 5; i++) begin
            check($sformatf("t4_order_len%0d", i), run_len, i);
            tick(1'b0, 1'b1);
        end
        check("t4_empty", count, 0);

        // Test 5: reset mid-run with two records queued.
        do_reset();
        run_of(1, 1'b0);
        run_of(2, 1'b0);
        check("t5_queued", count, 2);
        for (int i = 0; i < 4; i++) tick(1'b1, 1'b0);
        rst = 1'b1;
        tick(1'b1, 1'b0);
        rst = 1'b0;
        check("t5_valid_flushed", run_valid, 0);
        check("t5_count_flushed", count, 0);
        run_of(2, 1'b0);
        check("t5_len", run_len, 2);
        check("t5_count", count, 1);
        tick(1'b0, 1'b0);
        check("t5_no_extra", count, 1);

        // Test 6: random stream against a queue-based reference model.
        do_reset();
        q.delete();
        m_run = 0; m_cnt = 0; m_sat = 0; m_ovf = 0;
        for (int cyc = 0; cyc < 10000; cyc++) begin
            ra = ($urandom_range(0, 3) != 0);
            rr = ($urandom_range(0, 2) == 0);
            if (q.size() > 0 && rr) void'(q.pop_front());
            if (ra) begin
                if (!m_run) begin
                    m_run = 1; m_cnt = 1;
                end else if (m_cnt == 255) m_sat = 1;
                else m_cnt++;
            end else begin
                if (m_run) begin
                    if (q.size() < DEPTH) q.push_back('{len: m_cnt, sat: m_sat});
                    else m_ovf = 1;
                end
                m_run = 0; m_cnt = 0; m_sat = 0;
            end
            tick(ra, rr);
            check($sformatf("t6_count@%0d", cyc), count, q.size());
            check($sformatf("t6_valid@%0d", cyc), run_valid, (q.size() > 0));
            check($sformatf("t6_len@%0d", cyc), run_len, (q.size() > 0) ? q[0].len : 0);
            check($sformatf("t6_sat@%0d", cyc), run_sat, (q.size() > 0) ? q[0].sat : 0);
            check($sformatf("t6_ovf@%0d", cyc), overflow, m_ovf);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
